// File: rtl/uart_tx_mapper.sv
// CPU-facing 8N1 UART transmitter with a write buffer, status byte and transmit-complete interrupt.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry circular buffer; otherwise a single holding register is used.
module uart_tx_mapper #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       write_en,
  output logic [7:0] status_out,
  output logic       interupt,
  input  logic       clear_interupt,
  output logic       tx
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             overflow;
  logic [LVL_W-1:0] level;
  logic [7:0]       head_data;
  logic             buf_full;
  logic             buf_empty;
  logic             pop;
  logic             push;
  logic             drop;
  logic             baud_tick;

  // A pop in the same cycle frees a slot, so a write to a full buffer is still accepted then.
  assign buf_empty = (level == '0);
  assign pop       = (state == IDLE) && !buf_empty;
  assign push      = write_en && (!buf_full || pop);
  assign drop      = write_en && buf_full && !pop;
  assign baud_tick = (baud_cnt == '0);

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign buf_full  = (level == LVL_W'(FIFO_DEPTH));
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data_in;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`else
  logic [7:0] hold_reg;

  assign buf_full  = !buf_empty;
  assign head_data = hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= '0;
    end else begin
      if (push) begin
        hold_reg <= data_in;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tx        <= 1'b1;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      interupt  <= 1'b0;
    end else begin
      if (state != IDLE) begin
        baud_cnt <= baud_tick ? BIT_LAST : baud_cnt - 1'b1;
      end
      case (state)
        IDLE: begin
          if (!buf_empty) begin
            shift_reg <= head_data;
            tx        <= 1'b0;
            baud_cnt  <= BIT_LAST;
            state     <= START;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (baud_tick) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
              bit_idx   <= bit_idx + 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // Interrupt only fires when nothing is left to send; a new set beats a simultaneous clear.
      if (state == STOP && baud_tick && buf_empty) begin
        interupt <= 1'b1;
      end else if (clear_interupt) begin
        interupt <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clear_interupt) begin
      overflow <= 1'b0;
    end
  end

  // Status is a snapshot register, so it trails the buffer and FSM state by one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      status_out <= 8'h04;
    end else begin
      status_out <= {4'b0000, overflow, (buf_empty && state == IDLE), (state != IDLE), buf_full};
    end
  end

endmodule

// File: tb/tb_uart_tx_mapper.sv
// Self-checking bench for uart_tx_mapper: directed scenarios plus random traffic against a frame-timeline model.
// The model buffer depth follows UART_TX_FIFO_EN the same way the design does.
module tb_uart_tx_mapper;

  localparam int CPB       = 4;
  localparam int DEPTH_CFG = 4;
  localparam int FRAME     = 10 * CPB;
`ifdef UART_TX_FIFO_EN
  localparam int MODEL_DEPTH = DEPTH_CFG;
`else
  localparam int MODEL_DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       write_en;
  logic [7:0] status_out;
  logic       interupt;
  logic       clear_interupt;
  logic       tx;

  always #5 clk = ~clk;

  uart_tx_mapper #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH_CFG)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .write_en      (write_en),
    .status_out    (status_out),
    .interupt      (interupt),
    .clear_interupt(clear_interupt),
    .tx            (tx)
  );

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: pending bytes, and the byte on the wire with its elapsed cycles since the start edge.
  logic [7:0] byte_q[$];
  bit         m_busy    = 1'b0;
  int         m_elapsed = 0;
  logic [7:0] m_byte    = 8'h00;
  bit         m_int     = 1'b0;
  bit         m_ovf     = 1'b0;
  logic [7:0] m_status  = 8'h04;

  function automatic logic [7:0] model_status();
    return {4'b0000, m_ovf, (byte_q.size() == 0 && !m_busy), m_busy, (byte_q.size() == MODEL_DEPTH)};
  endfunction

  function automatic logic model_tx();
    int k;
    if (!m_busy) return 1'b1;
    k = m_elapsed / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_byte[k-1];
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input bit we, input logic [7:0] din, input bit clr, input bit r);
    bit set_int;
    bit dropped;
    set_int = 1'b0;
    dropped = 1'b0;
    if (r) begin
      byte_q.delete();
      m_busy    = 1'b0;
      m_elapsed = 0;
      m_int     = 1'b0;
      m_ovf     = 1'b0;
      m_status  = 8'h04;
      return;
    end
    m_status = model_status();
    if (m_busy) begin
      m_elapsed++;
      if (m_elapsed == FRAME) begin
        m_busy  = 1'b0;
        set_int = (byte_q.size() == 0);
      end
    end else if (byte_q.size() != 0) begin
      m_byte    = byte_q.pop_front();
      m_busy    = 1'b1;
      m_elapsed = 0;
    end
    if (we) begin
      if (byte_q.size() < MODEL_DEPTH) byte_q.push_back(din);
      else dropped = 1'b1;
    end
    if (set_int) m_int = 1'b1;
    else if (clr) m_int = 1'b0;
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic applyStimulus(input bit we, input logic [7:0] din, input bit clr, input bit r);
    write_en       = we;
    data_in        = din;
    clear_interupt = clr;
    rst            = r;
    @(posedge clk);
    modelStep(we, din, clr, r);
    #1;
    checkOutput("tx", tx, model_tx());
    checkOutput("interupt", interupt, m_int);
    checkOutput("status", status_out, m_status);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [9:0] pat;
    bit         found;
    bit         clr;

    write_en       = 1'b0;
    data_in        = 8'h00;
    clear_interupt = 1'b0;
    rst            = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("reset_status", status_out, 8'h04);
    checkOutput("reset_tx", tx, 1'b1);
    checkOutput("reset_int", interupt, 1'b0);

    // Single frame 8'hA5: start, LSB-first data, stop, each held CPB cycles.
    applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0);
    pat = 10'b1101001010;
    for (int i = 0; i < FRAME; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      checkOutput("a5_bit", tx, pat[i/CPB]);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("a5_int", interupt, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("a5_status", status_out, 8'h04);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("clr_int", interupt, 1'b0);

    // Six back-to-back writes overflow the buffer; clear is pulsed on the final stop expiry.
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 8'(i), 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("ovf_bit", status_out[3], 1'b1);
    found = 1'b0;
    for (int i = 0; i < 6 * (FRAME + 1) + 10 && !found; i++) begin
      clr = m_busy && (m_elapsed == FRAME - 1) && (byte_q.size() == 0);
      applyStimulus(1'b0, 8'h00, clr, 1'b0);
      if (clr) begin
        found = 1'b1;
        checkOutput("set_wins", interupt, 1'b1);
      end
    end
    checkOutput("last_stop_found", found, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("clr_int2", interupt, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("clr_ovf", status_out[3], 1'b0);

    // Byte written during STOP starts one cycle after the stop exits, with no interrupt in between.
    applyStimulus(1'b1, 8'h5A, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_busy && m_elapsed == 9 * CPB + 1) found = 1'b1;
      else applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("stop_found", found, 1'b1);
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 2 * CPB && !found; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
      if (!m_busy) found = 1'b1;
    end
    checkOutput("b2b_exit_found", found, 1'b1);
    checkOutput("b2b_no_int", interupt, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("b2b_start", tx, 1'b0);
    idleCycles(FRAME + 4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

    // Reset in the middle of data bit 3 with bytes still queued.
    applyStimulus(1'b1, 8'h81, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h24, 1'b0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_busy && m_elapsed == 4 * CPB + 1) found = 1'b1;
      else applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    end
    checkOutput("bit3_found", found, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("rst_tx", tx, 1'b1);
    checkOutput("rst_status", status_out, 8'h04);
    checkOutput("rst_int", interupt, 1'b0);
    idleCycles(FRAME + 5);
    checkOutput("rst_quiet_status", status_out, 8'h04);

    // Two writes back to back, then a third while the buffer is still occupied.
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    idleCycles(5);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("hold_ovf", status_out[3], (MODEL_DEPTH == 1) ? 1'b1 : 1'b0);
    idleCycles(3 * (FRAME + 1) + 4);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 1499) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
